// File: rtl/sram_port0_arbiter_if.sv
// Bus bundle between the two core-side requesters, the port-0 arbiter and the SRAM macro pins.
interface sram_port0_arbiter_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter int CNT_WIDTH  = 16
);
  logic                  arb_en;
  logic                  rq0_valid, rq0_ready, rq0_we;
  logic [NUM_WMASKS-1:0] rq0_wmask;
  logic [ADDR_WIDTH-1:0] rq0_addr;
  logic [DATA_WIDTH-1:0] rq0_wdata;
  logic                  rq1_valid, rq1_ready, rq1_we;
  logic [NUM_WMASKS-1:0] rq1_wmask;
  logic [ADDR_WIDTH-1:0] rq1_addr;
  logic [DATA_WIDTH-1:0] rq1_wdata;
  logic                  rsp0_valid, rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp0_rdata, rsp1_rdata;
  logic                  sram_csb0, sram_web0;
  logic [NUM_WMASKS-1:0] sram_wmask0;
  logic [ADDR_WIDTH-1:0] sram_addr0;
  logic [DATA_WIDTH-1:0] sram_din0, sram_dout0;
  logic [CNT_WIDTH-1:0]  grant_cnt0, grant_cnt1;

  modport slave (
    input  arb_en,
    input  rq0_valid, rq0_we, rq0_wmask, rq0_addr, rq0_wdata,
    input  rq1_valid, rq1_we, rq1_wmask, rq1_addr, rq1_wdata,
    input  sram_dout0,
    output rq0_ready, rq1_ready,
    output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    output sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
    output grant_cnt0, grant_cnt1
  );

  modport master (
    output arb_en,
    output rq0_valid, rq0_we, rq0_wmask, rq0_addr, rq0_wdata,
    output rq1_valid, rq1_we, rq1_wmask, rq1_addr, rq1_wdata,
    output sram_dout0,
    input  rq0_ready, rq1_ready,
    input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    input  sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
    input  grant_cnt0, grant_cnt1
  );
endinterface

// File: rtl/sram_port0_arbiter.sv
// Round-robin arbiter for SRAM port 0 with a 2-cycle in-order read pipeline.
// Optional saturating grant counters: define SRAM_ARB_GRANT_CNT_EN.
module sram_port0_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter int CNT_WIDTH  = 16
) (
  input logic                 clk,
  input logic                 rst,
  sram_port0_arbiter_if.slave bus
);
  logic [1:0]                 w_vld, w_we, w_gnt;
  logic [1:0][NUM_WMASKS-1:0] w_wmask;
  logic [1:0][ADDR_WIDTH-1:0] w_addr;
  logic [1:0][DATA_WIDTH-1:0] w_wdata;
  logic                       w_any, w_sel;
  logic                       r_last_gnt;
  logic [1:0]                 r_vld_pipe, r_own_pipe;
  logic [1:0][DATA_WIDTH-1:0] r_rdata;

  assign w_vld   = {bus.rq1_valid, bus.rq0_valid};
  assign w_we    = {bus.rq1_we,    bus.rq0_we};
  assign w_wmask = {bus.rq1_wmask, bus.rq0_wmask};
  assign w_addr  = {bus.rq1_addr,  bus.rq0_addr};
  assign w_wdata = {bus.rq1_wdata, bus.rq0_wdata};

  // On contention the requester that did not win last time gets the port.
  always_comb begin
    w_gnt = 2'b00;
    if (bus.arb_en && !rst) begin
      if (&w_vld) w_gnt = r_last_gnt ? 2'b01 : 2'b10;
      else        w_gnt = w_vld;
    end
  end

  assign w_any = |w_gnt;
  assign w_sel = w_gnt[1];

  assign bus.rq0_ready   = w_gnt[0];
  assign bus.rq1_ready   = w_gnt[1];
  assign bus.sram_csb0   = ~w_any;
  assign bus.sram_web0   = ~(w_any & w_we[w_sel]);
  assign bus.sram_wmask0 = w_any ? w_wmask[w_sel] : '0;
  assign bus.sram_addr0  = w_any ? w_addr[w_sel]  : '0;
  assign bus.sram_din0   = w_any ? w_wdata[w_sel] : '0;

  // vld_pipe[0]: macro is reading this cycle; vld_pipe[1]: response cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_gnt <= 1'b1;
      r_vld_pipe <= 2'b00;
      r_own_pipe <= 2'b00;
      r_rdata    <= '0;
    end else begin
      if (w_any) r_last_gnt <= w_sel;
      r_vld_pipe <= {r_vld_pipe[0], w_any & ~w_we[w_sel]};
      r_own_pipe <= {r_own_pipe[0], w_sel};
      if (r_vld_pipe[0]) r_rdata[r_own_pipe[0]] <= bus.sram_dout0;
    end
  end

  assign bus.rsp0_valid = r_vld_pipe[1] & ~r_own_pipe[1];
  assign bus.rsp1_valid = r_vld_pipe[1] &  r_own_pipe[1];
  assign bus.rsp0_rdata = r_rdata[0];
  assign bus.rsp1_rdata = r_rdata[1];

`ifdef SRAM_ARB_GRANT_CNT_EN
  logic [1:0][CNT_WIDTH-1:0] r_gcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gcnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (w_gnt[i] && !(&r_gcnt[i])) r_gcnt[i] <= r_gcnt[i] + CNT_WIDTH'(1);
    end
  end

  assign bus.grant_cnt0 = r_gcnt[0];
  assign bus.grant_cnt1 = r_gcnt[1];
`else
  assign bus.grant_cnt0 = {CNT_WIDTH{1'b0}};
  assign bus.grant_cnt1 = {CNT_WIDTH{1'b0}};
`endif
endmodule

// File: tb/tb_sram_port0_arbiter.sv
// Randomized + directed bench for sram_port0_arbiter against a transaction-level reference model.
module tb_sram_port0_arbiter;
  localparam int AW = 9, DW = 32, MW = 4, CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_port0_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW), .CNT_WIDTH(CW)) bus ();

  sram_port0_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // requester drive
  logic          arb_en;
  logic          rq_v [2];
  logic          rq_we[2];
  logic [MW-1:0] rq_mk[2];
  logic [AW-1:0] rq_ad[2];
  logic [DW-1:0] rq_wd[2];

  assign bus.arb_en    = arb_en;
  assign bus.rq0_valid = rq_v[0];  assign bus.rq1_valid = rq_v[1];
  assign bus.rq0_we    = rq_we[0]; assign bus.rq1_we    = rq_we[1];
  assign bus.rq0_wmask = rq_mk[0]; assign bus.rq1_wmask = rq_mk[1];
  assign bus.rq0_addr  = rq_ad[0]; assign bus.rq1_addr  = rq_ad[1];
  assign bus.rq0_wdata = rq_wd[0]; assign bus.rq1_wdata = rq_wd[1];

  // macro behaviour: registered inputs, dout valid the cycle after a read
  logic [DW-1:0] sram [512];
  initial bus.sram_dout0 = '0;
  always @(posedge clk) begin
    if (!bus.sram_csb0) begin
      if (!bus.sram_web0) begin
        for (int b = 0; b < MW; b++)
          if (bus.sram_wmask0[b]) sram[bus.sram_addr0][b*8 +: 8] <= bus.sram_din0[b*8 +: 8];
      end else begin
        bus.sram_dout0 <= sram[bus.sram_addr0];
      end
    end
  end

  // reference model: memory as seen at acceptance, pending responses, arbitration history
  typedef struct { int due; int own; logic [DW-1:0] d; } rsp_t;
  rsp_t          q[$];
  logic [DW-1:0] ref_mem[512];
  logic [DW-1:0] exp_rd[2];
  int            ref_last, cyc, last_g;
  int            ref_cnt[2];
  int            nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ref_last  = 1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    ref_cnt[0] = 0; ref_cnt[1] = 0;
  endtask

  task automatic preload(input int a, input logic [DW-1:0] d);
    sram[a] = d; ref_mem[a] = d;
  endtask

  task automatic set_rq(input int n, input logic v, input logic we, input logic [MW-1:0] mk,
                        input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    rq_v[n] = v; rq_we[n] = we; rq_mk[n] = mk; rq_ad[n] = ad; rq_wd[n] = wd;
  endtask

  task automatic idle();
    rq_v[0] = 1'b0; rq_v[1] = 1'b0;
  endtask

  function automatic int sat(input int c);
    return (c >= (1 << CW) - 1) ? (1 << CW) - 1 : c + 1;
  endfunction

  // Called at a negedge with inputs applied; checks the cycle and returns at the next negedge.
  task automatic step();
    int g;
    logic e0, e1;
    if (rst) model_reset();
    #1;
    g = -1;
    if (!rst && arb_en) begin
      if (rq_v[0] && rq_v[1]) g = (ref_last == 0) ? 1 : 0;
      else if (rq_v[0])       g = 0;
      else if (rq_v[1])       g = 1;
    end
    chk("ready0", bus.rq0_ready, g == 0);
    chk("ready1", bus.rq1_ready, g == 1);
    chk("csb0", bus.sram_csb0, g < 0);
    if (g >= 0) begin
      chk("web0",  bus.sram_web0,   !rq_we[g]);
      chk("addr0", bus.sram_addr0,  rq_ad[g]);
      chk("wmask", bus.sram_wmask0, rq_mk[g]);
      chk("din0",  bus.sram_din0,   rq_wd[g]);
    end else begin
      chk("web0_idle", bus.sram_web0, 1'b1);
      chk("pins_idle", {bus.sram_addr0, bus.sram_wmask0, bus.sram_din0}, '0);
    end
    e0 = 1'b0; e1 = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      if (q[0].own == 0) e0 = 1'b1; else e1 = 1'b1;
      exp_rd[q[0].own] = q[0].d;
      void'(q.pop_front());
    end
    chk("rsp0_valid", bus.rsp0_valid, e0);
    chk("rsp1_valid", bus.rsp1_valid, e1);
    chk("rsp0_rdata", bus.rsp0_rdata, exp_rd[0]);
    chk("rsp1_rdata", bus.rsp1_rdata, exp_rd[1]);
`ifdef SRAM_ARB_GRANT_CNT_EN
    chk("gcnt0", bus.grant_cnt0, ref_cnt[0]);
    chk("gcnt1", bus.grant_cnt1, ref_cnt[1]);
`else
    chk("gcnt0", bus.grant_cnt0, 0);
    chk("gcnt1", bus.grant_cnt1, 0);
`endif
    @(posedge clk);
    if (g >= 0) begin
      ref_last   = g;
      ref_cnt[g] = sat(ref_cnt[g]);
      if (rq_we[g]) begin
        for (int b = 0; b < MW; b++)
          if (rq_mk[g][b]) ref_mem[rq_ad[g]][b*8 +: 8] = rq_wd[g][b*8 +: 8];
      end else begin
        q.push_back('{due: cyc + 2, own: g, d: ref_mem[rq_ad[g]]});
      end
    end
    last_g = g;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) preload(i, $urandom);
    preload(9'h012, 32'hDEADBEEF);
    preload(9'h1FF, 32'h11223344);
    cyc = 0; last_g = -1;
    idle();
    for (int n = 0; n < 2; n++) set_rq(n, 1'b0, 1'b0, '0, '0, '0);
    arb_en = 1'b1;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    step(); step();
    rst = 1'b0;

    // single read
    set_rq(0, 1'b1, 1'b0, '0, 9'h012, '0); step();
    idle(); repeat (3) step();
    chk("single_rd_data", bus.rsp0_rdata, 32'hDEADBEEF);

    // byte-masked write then read
    set_rq(1, 1'b1, 1'b1, 4'b0101, 9'h1FF, 32'hAABBCCDD); step();
    set_rq(1, 1'b1, 1'b0, '0, 9'h1FF, '0); step();
    idle(); repeat (3) step();
    chk("bytewr_rd_data", bus.rsp1_rdata, 32'h11BB33DD);

    // reset with a read in flight, then contention
    set_rq(0, 1'b1, 1'b0, '0, 9'h005, '0); step();
    idle(); rst = 1'b1; step();
    rst = 1'b0; step(); step();
    set_rq(0, 1'b1, 1'b0, '0, 9'h020, '0);
    set_rq(1, 1'b1, 1'b0, '0, 9'h021, '0);
    #1 chk("first_contention_rq0", bus.rq0_ready, 1'b1);
    repeat (6) step();
    idle(); repeat (3) step();

    // back-to-back reads from rq0
    for (int i = 0; i < 4; i++) begin
      set_rq(0, 1'b1, 1'b0, '0, AW'(i), '0); step();
    end
    idle(); repeat (3) step();

    // counter saturation
    rst = 1'b1; step(); rst = 1'b0;
    set_rq(1, 1'b1, 1'b0, '0, 9'h033, '0);
    repeat (20) step();
    idle(); repeat (3) step();
`ifdef SRAM_ARB_GRANT_CNT_EN
    chk("cnt1_saturated", bus.grant_cnt1, 15);
`else
    chk("cnt1_disabled", bus.grant_cnt1, 0);
`endif
    chk("cnt0_zero", bus.grant_cnt0, 0);

    // random traffic; requests hold while waiting
    for (int c = 0; c < 600; c++) begin
      for (int n = 0; n < 2; n++)
        if (!(rq_v[n] && last_g != n && c > 0))
          set_rq(n, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, MW'($urandom),
                 AW'($urandom_range(0, 15)), $urandom);
      arb_en = $urandom_range(0, 7) != 0;
      rst    = $urandom_range(0, 59) == 0;
      step();
      rst = 1'b0;
    end
    idle(); arb_en = 1'b1;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
